// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default geometry, hardwired-zero index and busy-vector type.
package regfile_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_REG_BITS = 4;
   localparam int DEF_DEPTH    = 2 ** DEF_REG_BITS;
   localparam int ZERO_IDX     = 0;

   typedef logic [DEF_DEPTH-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-write scoreboard.
// Ports: clk/reset, clear (clr_en/clr_index), set (set_en/set_index),
// lookups A_index/B_index -> A_busy/B_busy, any_busy (OR of all bits).
module regfile_busy_tracker
   import regfile_pkg::*;
#(
   parameter int REG_BITS = DEF_REG_BITS,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr_en,
   input  logic [REG_BITS-1:0] clr_index,
   input  logic                set_en,
   input  logic [REG_BITS-1:0] set_index,
   input  logic [REG_BITS-1:0] A_index,
   input  logic [REG_BITS-1:0] B_index,
   output logic                A_busy,
   output logic                B_busy,
   output logic                any_busy
);

   localparam int DEPTH = 2 ** REG_BITS;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   // Set is applied after clear: a new load issued in the same cycle
   // that the previous one retires keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (clr_en)
         busy_nxt[clr_index] = 1'b0;
      if (set_en)
         busy_nxt[set_index] = 1'b1;
      if (ZERO_REG != 0)
         busy_nxt[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign A_busy   = busy[A_index];
   assign B_busy   = busy[B_index];
   assign any_busy = |busy;

endmodule

// File: rtl/regfile_scoreboard_bypass.sv
// Two-read/one-write register file with optional write bypass and a
// busy scoreboard. Ports: write (reg_write/write_index/write_data),
// reads A/B (index -> data, busy), busy_set/busy_index, any_busy.
module regfile_scoreboard_bypass
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int REG_BITS = DEF_REG_BITS,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reg_write,
   input  logic [REG_BITS-1:0] write_index,
   input  logic [WIDTH-1:0]    write_data,
   input  logic [REG_BITS-1:0] A_index,
   input  logic [REG_BITS-1:0] B_index,
   output logic [WIDTH-1:0]    A_data,
   output logic [WIDTH-1:0]    B_data,
   input  logic                busy_set,
   input  logic [REG_BITS-1:0] busy_index,
   output logic                A_busy,
   output logic                B_busy,
   output logic                any_busy
);

   localparam int DEPTH = 2 ** REG_BITS;
   localparam logic [REG_BITS-1:0] ZIDX = REG_BITS'(ZERO_IDX);

   logic [WIDTH-1:0] ram [DEPTH];

   logic wr_zero;
   logic a_zero;
   logic b_zero;
   logic wr_ok;
   logic a_fwd;
   logic b_fwd;
   logic a_busy_raw;
   logic b_busy_raw;

   assign wr_zero = (ZERO_REG != 0) && (write_index == ZIDX);
   assign a_zero  = (ZERO_REG != 0) && (A_index == ZIDX);
   assign b_zero  = (ZERO_REG != 0) && (B_index == ZIDX);
   assign wr_ok   = reg_write && !wr_zero;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            ram[i] <= '0;
      end else if (wr_ok) begin
         ram[write_index] <= write_data;
      end
   end

   // Forwarding only fires for a real (non-hardwired) write target.
   assign a_fwd = (BYPASS != 0) && wr_ok && (write_index == A_index);
   assign b_fwd = (BYPASS != 0) && wr_ok && (write_index == B_index);

   always_comb begin
      A_data = ram[A_index];
      if (a_zero)
         A_data = '0;
      else if (a_fwd)
         A_data = write_data;
   end

   always_comb begin
      B_data = ram[B_index];
      if (b_zero)
         B_data = '0;
      else if (b_fwd)
         B_data = write_data;
   end

   regfile_busy_tracker #(
      .REG_BITS (REG_BITS),
      .ZERO_REG (ZERO_REG)
   ) u_busy (
      .clk       (clk),
      .reset     (reset),
      .clr_en    (reg_write),
      .clr_index (write_index),
      .set_en    (busy_set),
      .set_index (busy_index),
      .A_index   (A_index),
      .B_index   (B_index),
      .A_busy    (a_busy_raw),
      .B_busy    (b_busy_raw),
      .any_busy  (any_busy)
   );

   // A forwarded value satisfies the pending write, so don't stall on it.
   assign A_busy = a_busy_raw && !a_fwd;
   assign B_busy = b_busy_raw && !b_fwd;

endmodule
